// File: rtl/biriscv_inst_encoder.sv
// RV32I instruction assembler: checks and encodes commands into a PC-tagged output FIFO; optional M ops via BIRISCV_INST_ENC_MUL_EN.
// Accepted command appears on the outputs one edge later; cmd_ready_o drops while the FIFO is full, illegal commands are consumed and counted.
module biriscv_inst_encoder #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] PC_RESET   = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [5:0]  cmd_op_i,
   input  logic [4:0]  cmd_rd_i,
   input  logic [4:0]  cmd_rs1_i,
   input  logic [4:0]  cmd_rs2_i,
   input  logic [31:0] cmd_imm_i,
   input  logic        pc_set_i,
   input  logic [31:0] pc_value_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_pc_o,
   output logic [31:0] out_opcode_o,
   output logic        err_o,
   input  logic        err_clr_i,
   output logic [7:0]  drop_cnt_o
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [2:0] {F_R, F_SH, F_I, F_S, F_B, F_U, F_J, F_FIX} fmt_e;

   logic [31:0]   pc_mem [FIFO_DEPTH];
   logic [31:0]   op_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_q, pc_d, entry_pc;
   logic          err_q, err_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   logic          legal, accept, push, drop, pop;
   logic [31:0]   word, fix_word;
   fmt_e          fmt;
   logic [2:0]    f3;
   logic [6:0]    f7, opc;
   logic          ok_i, ok_sh, ok_u, ok_b, ok_j;

   // Range checks reduce to "upper bits are a pure sign extension"
   assign ok_i  = (cmd_imm_i[31:11] == '0) || (cmd_imm_i[31:11] == '1);
   assign ok_sh = (cmd_imm_i[31:5] == '0);
   assign ok_u  = (cmd_imm_i[11:0] == '0);
   assign ok_b  = ((cmd_imm_i[31:12] == '0) || (cmd_imm_i[31:12] == '1)) && !cmd_imm_i[0];
   assign ok_j  = ((cmd_imm_i[31:20] == '0) || (cmd_imm_i[31:20] == '1)) && !cmd_imm_i[0];

   always_comb begin
      legal    = 1'b0;
      fmt      = F_FIX;
      f3       = 3'd0;
      f7       = 7'd0;
      opc      = 7'd0;
      fix_word = 32'd0;
      case (cmd_op_i)
         6'd0:  begin fmt = F_I;  f3 = 3'd0; opc = OPC_OPIMM;  legal = ok_i;  end
         6'd1:  begin fmt = F_I;  f3 = 3'd7; opc = OPC_OPIMM;  legal = ok_i;  end
         6'd2:  begin fmt = F_I;  f3 = 3'd6; opc = OPC_OPIMM;  legal = ok_i;  end
         6'd3:  begin fmt = F_I;  f3 = 3'd4; opc = OPC_OPIMM;  legal = ok_i;  end
         6'd4:  begin fmt = F_I;  f3 = 3'd2; opc = OPC_OPIMM;  legal = ok_i;  end
         6'd5:  begin fmt = F_I;  f3 = 3'd3; opc = OPC_OPIMM;  legal = ok_i;  end
         6'd6:  begin fmt = F_SH; f3 = 3'd1; opc = OPC_OPIMM;  legal = ok_sh; end
         6'd7:  begin fmt = F_SH; f3 = 3'd5; opc = OPC_OPIMM;  legal = ok_sh; end
         6'd8:  begin fmt = F_SH; f3 = 3'd5; f7 = 7'h20; opc = OPC_OPIMM; legal = ok_sh; end
         6'd9:  begin fmt = F_U;  opc = OPC_LUI;   legal = ok_u; end
         6'd10: begin fmt = F_U;  opc = OPC_AUIPC; legal = ok_u; end
         6'd11: begin fmt = F_R;  f3 = 3'd0; opc = OPC_OP; legal = 1'b1; end
         6'd12: begin fmt = F_R;  f3 = 3'd0; f7 = 7'h20; opc = OPC_OP; legal = 1'b1; end
         6'd13: begin fmt = F_R;  f3 = 3'd2; opc = OPC_OP; legal = 1'b1; end
         6'd14: begin fmt = F_R;  f3 = 3'd3; opc = OPC_OP; legal = 1'b1; end
         6'd15: begin fmt = F_R;  f3 = 3'd4; opc = OPC_OP; legal = 1'b1; end
         6'd16: begin fmt = F_R;  f3 = 3'd6; opc = OPC_OP; legal = 1'b1; end
         6'd17: begin fmt = F_R;  f3 = 3'd7; opc = OPC_OP; legal = 1'b1; end
         6'd18: begin fmt = F_R;  f3 = 3'd1; opc = OPC_OP; legal = 1'b1; end
         6'd19: begin fmt = F_R;  f3 = 3'd5; opc = OPC_OP; legal = 1'b1; end
         6'd20: begin fmt = F_R;  f3 = 3'd5; f7 = 7'h20; opc = OPC_OP; legal = 1'b1; end
         6'd21: begin fmt = F_J;  opc = OPC_JAL; legal = ok_j; end
         6'd22: begin fmt = F_I;  f3 = 3'd0; opc = OPC_JALR; legal = ok_i; end
         6'd23: begin fmt = F_B;  f3 = 3'd0; opc = OPC_BRANCH; legal = ok_b; end
         6'd24: begin fmt = F_B;  f3 = 3'd1; opc = OPC_BRANCH; legal = ok_b; end
         6'd25: begin fmt = F_B;  f3 = 3'd4; opc = OPC_BRANCH; legal = ok_b; end
         6'd26: begin fmt = F_B;  f3 = 3'd5; opc = OPC_BRANCH; legal = ok_b; end
         6'd27: begin fmt = F_B;  f3 = 3'd6; opc = OPC_BRANCH; legal = ok_b; end
         6'd28: begin fmt = F_B;  f3 = 3'd7; opc = OPC_BRANCH; legal = ok_b; end
         6'd29: begin fmt = F_I;  f3 = 3'd0; opc = OPC_LOAD; legal = ok_i; end
         6'd30: begin fmt = F_I;  f3 = 3'd1; opc = OPC_LOAD; legal = ok_i; end
         6'd31: begin fmt = F_I;  f3 = 3'd2; opc = OPC_LOAD; legal = ok_i; end
         6'd32: begin fmt = F_I;  f3 = 3'd4; opc = OPC_LOAD; legal = ok_i; end
         6'd33: begin fmt = F_I;  f3 = 3'd5; opc = OPC_LOAD; legal = ok_i; end
         6'd34: begin fmt = F_S;  f3 = 3'd0; opc = OPC_STORE; legal = ok_i; end
         6'd35: begin fmt = F_S;  f3 = 3'd1; opc = OPC_STORE; legal = ok_i; end
         6'd36: begin fmt = F_S;  f3 = 3'd2; opc = OPC_STORE; legal = ok_i; end
         6'd37: begin fix_word = 32'h0000_0073; legal = 1'b1; end
         6'd38: begin fix_word = 32'h0010_0073; legal = 1'b1; end
         6'd39: begin fix_word = 32'h0000_100F; legal = 1'b1; end
`ifdef BIRISCV_INST_ENC_MUL_EN
         6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47: begin
            fmt = F_R; f3 = cmd_op_i[2:0]; f7 = 7'b0000001; opc = OPC_OP; legal = 1'b1;
         end
`endif
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      case (fmt)
         F_R:     word = {f7, cmd_rs2_i, cmd_rs1_i, f3, cmd_rd_i, opc};
         F_SH:    word = {f7, cmd_imm_i[4:0], cmd_rs1_i, f3, cmd_rd_i, opc};
         F_I:     word = {cmd_imm_i[11:0], cmd_rs1_i, f3, cmd_rd_i, opc};
         F_S:     word = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, f3, cmd_imm_i[4:0], opc};
         F_B:     word = {cmd_imm_i[12], cmd_imm_i[10:5], cmd_rs2_i, cmd_rs1_i, f3,
                          cmd_imm_i[4:1], cmd_imm_i[11], opc};
         F_U:     word = {cmd_imm_i[31:12], cmd_rd_i, opc};
         F_J:     word = {cmd_imm_i[20], cmd_imm_i[10:1], cmd_imm_i[11], cmd_imm_i[19:12],
                          cmd_rd_i, opc};
         default: word = fix_word;
      endcase
   end

   assign cmd_ready_o  = (count_q != FULL);
   assign out_valid_o  = (count_q != '0);
   assign out_pc_o     = out_valid_o ? pc_mem[rd_ptr_q] : 32'd0;
   assign out_opcode_o = out_valid_o ? op_mem[rd_ptr_q] : 32'd0;
   assign err_o        = err_q;
   assign drop_cnt_o   = drop_cnt_q;

   assign accept   = cmd_valid_i & cmd_ready_o;
   assign push     = accept & legal;
   assign drop     = accept & ~legal;
   assign pop      = out_valid_o & out_ready_i;
   assign entry_pc = pc_set_i ? (pc_value_i & ~32'd3) : pc_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      // A dropped command with pc_set_i still loads the PC, it just does not advance it
      pc_d = pc_q;
      if (push)          pc_d = entry_pc + 32'd4;
      else if (pc_set_i) pc_d = pc_value_i & ~32'd3;

      err_d = err_q;
      if (err_clr_i) err_d = 1'b0;
      else if (drop) err_d = 1'b1;

      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         pc_mem[wr_ptr_q] <= entry_pc;
         op_mem[wr_ptr_q] <= word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pc_q       <= PC_RESET;
         err_q      <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q    <= count_d;
         pc_q       <= pc_d;
         err_q      <= err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
endmodule

// File: tb/tb_biriscv_inst_encoder.sv
// Directed vector bench for biriscv_inst_encoder: encoding table plus backpressure, PC, error and reset sequences.
module tb_biriscv_inst_encoder;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [5:0]  cmd_op_i;
   logic [4:0]  cmd_rd_i, cmd_rs1_i, cmd_rs2_i;
   logic [31:0] cmd_imm_i;
   logic        pc_set_i;
   logic [31:0] pc_value_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_pc_o, out_opcode_o;
   logic        err_o;
   logic        err_clr_i;
   logic [7:0]  drop_cnt_o;

   biriscv_inst_encoder #(.FIFO_DEPTH(4), .PC_RESET(32'h8000_0000)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
      .cmd_imm_i(cmd_imm_i), .pc_set_i(pc_set_i), .pc_value_i(pc_value_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
      .out_opcode_o(out_opcode_o), .err_o(err_o), .err_clr_i(err_clr_i), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   localparam int NV = 24;
   vec_t        vec [NV];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   int          exp_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
      cmd_op_i = op; cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2; cmd_imm_i = imm;
      cmd_valid_i = 1'b1;
   endtask

   initial begin
      vec[0]  = '{6'd0,  5'd10, 5'd0,  5'd0,  32'd1,          1'b1, 32'h00100513}; // ADDI
      vec[1]  = '{6'd11, 5'd10, 5'd11, 5'd12, 32'd0,          1'b1, 32'h00C58533}; // ADD
      vec[2]  = '{6'd36, 5'd0,  5'd2,  5'd11, 32'd8,          1'b1, 32'h00B12423}; // SW
      vec[3]  = '{6'd21, 5'd1,  5'd0,  5'd0,  32'd8,          1'b1, 32'h008000EF}; // JAL
      vec[4]  = '{6'd23, 5'd0,  5'd1,  5'd2,  32'd3,          1'b0, 32'h0};        // BEQ odd
      vec[5]  = '{6'd9,  5'd5,  5'd0,  5'd0,  32'h12345001,   1'b0, 32'h0};        // LUI low bits
      vec[6]  = '{6'd55, 5'd1,  5'd1,  5'd1,  32'd0,          1'b0, 32'h0};        // illegal op
      vec[7]  = '{6'd12, 5'd1,  5'd2,  5'd3,  32'd0,          1'b1, 32'h403100B3}; // SUB
      vec[8]  = '{6'd9,  5'd5,  5'd0,  5'd0,  32'h12345000,   1'b1, 32'h123452B7}; // LUI
      vec[9]  = '{6'd10, 5'd2,  5'd0,  5'd0,  32'h00001000,   1'b1, 32'h00001117}; // AUIPC
      vec[10] = '{6'd8,  5'd1,  5'd1,  5'd0,  32'd31,         1'b1, 32'h41F0D093}; // SRAI 31
      vec[11] = '{6'd6,  5'd1,  5'd1,  5'd0,  32'd32,         1'b0, 32'h0};        // SLLI 32
      vec[12] = '{6'd24, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,   1'b1, 32'hFE209EE3}; // BNE -4
      vec[13] = '{6'd28, 5'd0,  5'd0,  5'd0,  32'd4094,       1'b1, 32'h7E007FE3}; // BGEU max
      vec[14] = '{6'd0,  5'd1,  5'd0,  5'd0,  32'hFFFFF800,   1'b1, 32'h80000093}; // ADDI -2048
      vec[15] = '{6'd0,  5'd1,  5'd0,  5'd0,  32'd2048,       1'b0, 32'h0};        // ADDI 2048
      vec[16] = '{6'd31, 5'd3,  5'd2,  5'd0,  32'd2047,       1'b1, 32'h7FF12183}; // LW 2047
      vec[17] = '{6'd22, 5'd1,  5'd5,  5'd0,  32'hFFFFFFF8,   1'b1, 32'hFF8280E7}; // JALR -8
      vec[18] = '{6'd21, 5'd0,  5'd0,  5'd0,  32'hFFF00000,   1'b1, 32'h8000006F}; // JAL -2^20
      vec[19] = '{6'd21, 5'd0,  5'd0,  5'd0,  32'h00100000,   1'b0, 32'h0};        // JAL 2^20
      vec[20] = '{6'd37, 5'd0,  5'd0,  5'd0,  32'd0,          1'b1, 32'h00000073}; // ECALL
      vec[21] = '{6'd38, 5'd0,  5'd0,  5'd0,  32'd0,          1'b1, 32'h00100073}; // EBREAK
      vec[22] = '{6'd39, 5'd0,  5'd0,  5'd0,  32'd0,          1'b1, 32'h0000100F}; // FENCE.I
`ifdef BIRISCV_INST_ENC_MUL_EN
      vec[23] = '{6'd40, 5'd10, 5'd11, 5'd12, 32'd0,          1'b1, 32'h02C58533}; // MUL
`else
      vec[23] = '{6'd40, 5'd10, 5'd11, 5'd12, 32'd0,          1'b0, 32'h0};        // MUL off
`endif

      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_rd_i = '0; cmd_rs1_i = '0;
      cmd_rs2_i = '0; cmd_imm_i = '0; pc_set_i = 1'b0; pc_value_i = '0;
      out_ready_i = 1'b1; err_clr_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i); rst_i = 1'b0;
      chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_pc", out_pc_o, 32'd0);
      chk("rst_opcode", out_opcode_o, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
      exp_pc = 32'h8000_0000;
      exp_drop = 0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk_i);
         drive(vec[i].op, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].imm);
         @(posedge clk_i); #1;
         cmd_valid_i = 1'b0;
         if (vec[i].legal) begin
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("v%0d_opcode", i), out_opcode_o, vec[i].word);
            chk($sformatf("v%0d_pc", i), out_pc_o, exp_pc);
            exp_pc = exp_pc + 32'd4;
         end else begin
            exp_drop++;
            chk($sformatf("v%0d_novalid", i), {31'd0, out_valid_o}, 32'd0);
            chk($sformatf("v%0d_err", i), {31'd0, err_o}, 32'd1);
            chk($sformatf("v%0d_drop", i), {24'd0, drop_cnt_o}, exp_drop);
         end
         @(posedge clk_i); #1;
      end

      // err clear, and clear winning over a simultaneous drop
      @(negedge clk_i); err_clr_i = 1'b1;
      @(posedge clk_i); #1;
      chk("clr_err", {31'd0, err_o}, 32'd0);
      chk("clr_drop", {24'd0, drop_cnt_o}, exp_drop);
      drive(6'd60, 5'd0, 5'd0, 5'd0, 32'd0);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0; err_clr_i = 1'b0; exp_drop++;
      chk("clrwin_err", {31'd0, err_o}, 32'd0);
      chk("clrwin_drop", {24'd0, drop_cnt_o}, exp_drop);

      // backpressure: fill with the consumer stalled
      @(negedge clk_i); out_ready_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i); drive(6'd0, 5'd1, 5'd0, 5'd0, k);
         @(posedge clk_i); #1;
         chk($sformatf("bp_head%0d", k), out_opcode_o, 32'h00100093);
      end
      chk("bp_full", {31'd0, cmd_ready_o}, 32'd0);
      drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      repeat (2) @(posedge clk_i); #1;
      chk("bp_still_full", {31'd0, cmd_ready_o}, 32'd0);
      chk("bp_stable_op", out_opcode_o, 32'h00100093);
      chk("bp_stable_pc", out_pc_o, exp_pc);
      @(negedge clk_i); out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("bp_pop1_op", out_opcode_o, 32'h00200093);
      chk("bp_pop1_ready", {31'd0, cmd_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("bp_pop2_op", out_opcode_o, 32'h00300093);
      @(posedge clk_i); #1;
      chk("bp_pop3_op", out_opcode_o, 32'h00400093);
      @(posedge clk_i); #1;
      chk("bp_fifth_op", out_opcode_o, 32'h00500093);
      chk("bp_fifth_pc", out_pc_o, exp_pc + 32'd16);
      @(posedge clk_i); #1;
      chk("bp_empty", {31'd0, out_valid_o}, 32'd0);

      // PC load with same-cycle accept, then wrap past 2^32
      @(negedge clk_i);
      pc_set_i = 1'b1; pc_value_i = 32'hFFFF_FFFE;
      drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd1);
      @(posedge clk_i); #1;
      pc_set_i = 1'b0;
      chk("pcset_pc", out_pc_o, 32'hFFFF_FFFC);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("pcwrap_pc", out_pc_o, 32'h0000_0000);
      @(posedge clk_i); #1;
      pc_set_i = 1'b1; pc_value_i = 32'h0000_0103;
      @(posedge clk_i); #1;
      pc_set_i = 1'b0;
      chk("pcload_novalid", {31'd0, out_valid_o}, 32'd0);
      drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd1);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("pcload_pc", out_pc_o, 32'h0000_0100);
      @(posedge clk_i); #1;

      // drop counter saturation
      drive(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
      repeat (260) @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
      chk("drop_sat", {24'd0, drop_cnt_o}, 32'd255);

      // reset mid-stream discards buffered entries
      out_ready_i = 1'b0;
      drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd7);
      repeat (2) @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("mid_valid", {31'd0, out_valid_o}, 32'd1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("mid_rst_drop", {24'd0, drop_cnt_o}, 32'd0);
      out_ready_i = 1'b1;
      drive(6'd0, 5'd1, 5'd0, 5'd0, 32'd7);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("mid_rst_pc", out_pc_o, 32'h8000_0000);
      chk("mid_rst_op", out_opcode_o, 32'h00700093);
      @(posedge clk_i); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/biriscv_inst_encoder.md
Name: biriscv_inst_encoder

Overview:
- Instruction assembler for simulation and debug instruction injection. It is the encode direction of the trace decoder's opcode format.
- Accepts structured commands (operation, rd, rs1, rs2, immediate) over a valid/ready handshake and checks immediate legality.
- Encodes each legal command to a 32-bit RV32I word and buffers it in a FIFO with an auto-incrementing PC.
- Output triple (valid, pc, opcode) matches the trace monitor inputs, so the stream can drive the trace monitor or a fetch-injection port directly.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- PC_RESET, 32'h8000_0000, PC value after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_op_i  in  6  operation enumeration (see Behaviour).
- cmd_rd_i  in  5  destination register.
- cmd_rs1_i  in  5  source register 1.
- cmd_rs2_i  in  5  source register 2.
- cmd_imm_i  in  32  immediate, signed byte offset or value.
- pc_set_i  in  1  load PC.
- pc_value_i  in  32  new PC; bits [1:0] forced to 0.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer pops head.
- out_pc_o  out  32  PC of head instruction.
- out_opcode_o  out  32  encoded instruction word.
- err_o  out  1  sticky: a command was dropped.
- err_clr_i  in  1  clear err_o.
- drop_cnt_o  out  8  dropped-command count, saturating at 255.

Behaviour:
- Op enumeration (decimal):
  - 0-8: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - 9-10: LUI, AUIPC.
  - 11-20: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA.
  - 21-22: JAL, JALR.
  - 23-28: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 29-33: LB, LH, LW, LBU, LHU.
  - 34-36: SB, SH, SW.
  - 37-39: ECALL, EBREAK, FENCE.I.
  - 40-47: M-extension (optional feature).
  - 48-63: illegal.
- Field use per format:
  - I: rd, rs1, imm[11:0].
  - Shift: rd, rs1, shamt = imm[4:0].
  - U: rd, imm[31:12].
  - R: rd, rs1, rs2.
  - J: rd, offset.
  - B: rs1, rs2, offset.
  - S: rs1 (base), rs2 (data), offset.
  - SYSTEM/FENCE.I: fixed words 0x00000073, 0x00100073, 0x0000100F.
- Legality checks (fail = drop):
  - I/load/S/JALR: imm in [-2048, 2047].
  - Shift: imm in [0, 31].
  - U: imm[11:0] == 0.
  - B: imm in [-4096, 4094], even.
  - J: imm in [-2^20, 2^20-2], even.
  - Op 48-63, or 40-47 with the feature disabled: drop.
- Accept and drop:
  - Acceptance happens on cmd_valid_i & cmd_ready_o.
  - A legal command is encoded combinationally and written to the FIFO at that edge.
  - An illegal command is still accepted and is not written. At that edge err_o is set and drop_cnt_o increments.
- Latency: command accepted at edge N is visible on the outputs after edge N, when the FIFO was empty.
- Backpressure: cmd_ready_o = (count != FIFO_DEPTH), derived from registered state. A pop in the same cycle does not raise ready.
- Pop: on out_valid_o & out_ready_i. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- out_pc_o/out_opcode_o are held stable while out_valid_o & !out_ready_i.
- PC register:
  - Each legal write stores the current PC with the word, then PC += 4, wrapping at 2^32.
  - Drops do not advance the PC.
  - pc_set_i in the same cycle as an accept: the accepted instruction gets pc_value_i & ~3, and the next PC is that value + 4.
  - pc_set_i with no accept: PC loads the new value.
- Error register: err_clr_i wins over a same-cycle set; drop_cnt_o is unaffected by err_clr_i.
- Reset: FIFO emptied, out_valid_o=0, out_pc_o=0, out_opcode_o=0, cmd_ready_o=1 from the cycle after reset, PC=PC_RESET, err_o=0, drop_cnt_o=0. Reset mid-stream discards all buffered entries.

Optional Feature:
- Macro: BIRISCV_INST_ENC_MUL_EN.
- Defined: ops 40-47 encode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. These are R-type with funct7=0000001 and funct3 0-7.
- Undefined: ops 40-47 are illegal and dropped; no M-extension logic is present.

Test Plan:
- Reset, then ADDI rd=10 rs1=0 imm=1 -> next cycle out_valid_o=1, out_opcode_o=0x00100513, out_pc_o=0x80000000. Then ADD rd=10 rs1=11 rs2=12 -> 0x00C58533 at pc 0x80000004.
- SW rs1=2 rs2=11 imm=8 -> 0x00B12423. JAL rd=1 imm=8 -> 0x008000EF.
- BEQ imm=3, then LUI imm=0x12345001, then op=55 -> all three dropped, err_o=1, drop_cnt_o=3, PC unchanged. err_clr_i -> err_o=0, count stays 3.
- out_ready_i=0, push 5 legal commands with FIFO_DEPTH=4 -> cmd_ready_o=0 after the 4th. Release -> 4 words in order, head stable while stalled, 5th accepted after the first pop.
- pc_set_i=1 with pc_value_i=0xFFFFFFFE plus a same-cycle ADDI, then a 2nd ADDI -> pcs 0xFFFFFFFC, then 0x00000000 (wrap).
- With BIRISCV_INST_ENC_MUL_EN: MUL rd=10 rs1=11 rs2=12 -> 0x02C58533. Without the macro: the same command is dropped and err_o=1.
